// File: rtl/sad_search_ctrl_if.sv
// rtl/sad_search_ctrl_if.sv - start/abort, candidate issue, SAD return and best-result bundle
interface sad_search_ctrl_if #(
    parameter int SAD_W = 14,
    parameter int IDX_W = 3
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_valid;
    logic             cand_ready;
    logic [SAD_W-1:0] sad_in;
    logic             sad_valid;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             best_valid;

    // Environment side: ME top-level FSM plus the SAD engine.
    modport master (
        output start, abort, cand_ready, sad_in, sad_valid,
        input  busy, done, cand_idx, cand_valid, best_sad, best_idx, best_valid
    );

    // Search controller side.
    modport slave (
        input  start, abort, cand_ready, sad_in, sad_valid,
        output busy, done, cand_idx, cand_valid, best_sad, best_idx, best_valid
    );
endinterface

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - motion-estimation candidate search sequencer; optional SAD_SEARCH_EARLY_EXIT_EN
module sad_search_ctrl #(
    parameter int SAD_W       = 14,
    parameter int NUM_CAND    = 5,
    parameter int IDX_W       = 3,
    parameter int EXIT_THRESH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    sad_search_ctrl_if.slave bus
);
    localparam int               CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_CAND);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(NUM_CAND - 1);
    localparam logic [SAD_W-1:0] THRESH  = SAD_W'(EXIT_THRESH);
`ifdef SAD_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] recv;
    logic             aborted;
    logic             best_valid_q;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             cand_valid;
    logic             done;

    logic issue_fire;
    logic result_fire;
    logic run_result;
    logic better;
    logic exit_hit;

    assign issue_fire  = cand_valid && bus.cand_ready;
    // A result is only meaningful while something is outstanding; stray
    // sad_valid pulses can never push recv past issued.
    assign result_fire = bus.sad_valid && (state != IDLE) && (recv < issued);
    assign run_result  = result_fire && (state == RUN);
    // recv==0 marks the first result of the search; strict < keeps the
    // earlier (lower) index on ties.
    assign better      = (recv == '0) || (bus.sad_in < best_sad);
    assign exit_hit    = EARLY_EXIT && (bus.sad_in <= THRESH);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus candidate-valid and done strobes.
    always_comb begin
        state_nxt  = state;
        cand_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cand_valid = (issued < LAST);
                if (bus.abort) begin
                    state_nxt = DRAIN;
                end else if (run_result && ((recv == LAST_M1) || exit_hit)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (issued == recv) begin
                    state_nxt = IDLE;
                    done      = !aborted;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue/receive counters and the abort flag; cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued  <= '0;
            recv    <= '0;
            aborted <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                issued  <= '0;
                recv    <= '0;
                aborted <= 1'b0;
            end
        end else begin
            if (issue_fire) begin
                issued <= issued + 1'b1;
            end
            if (result_fire) begin
                recv <= recv + 1'b1;
            end
            if ((state == RUN) && bus.abort) begin
                aborted <= 1'b1;
            end
        end
    end

    // Running minimum; only results accepted in RUN may touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= '0;
            best_idx <= '0;
        end else if (run_result && better) begin
            best_sad <= bus.sad_in;
            best_idx <= recv[IDX_W-1:0];
        end
    end

    // best_valid latches on done and clears on the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid_q <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            best_valid_q <= 1'b0;
        end else if (done) begin
            best_valid_q <= 1'b1;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;
    assign bus.cand_valid = cand_valid;
    assign bus.cand_idx   = issued[IDX_W-1:0];
    assign bus.best_sad   = best_sad;
    assign bus.best_idx   = best_idx;
    assign bus.best_valid = best_valid_q | done;
endmodule
